// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern, length and overlap mode.
// Optional match counter is compiled in when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             data_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HUNT = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] pat_reg;
    logic [LEN_W-1:0] len_reg;
    logic             overlap_reg;
    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] fill;
    logic             match_q;

    logic [LEN_W-1:0] len_clamped;
    logic             accept;
    logic [PAT_W-1:0] history_next;
    logic [LEN_W-1:0] fill_next;
    logic             filled;
    logic [PAT_W-1:0] pat_mask;
    logic             hit;

    // Zero length degenerates to a single bit; oversize lengths use the whole register.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            len_clamped = LEN_W'(PAT_W);
        end
    end

    // A load in the same cycle takes priority, so the concurrent bit is dropped.
    assign accept       = in_valid && !cfg_load && (state_q != ST_IDLE);
    assign history_next = {history[PAT_W-2:0], data_in};
    assign fill_next    = (fill >= len_reg) ? len_reg : fill + LEN_W'(1);
    assign filled       = (fill_next >= len_reg);

    always_comb begin
        pat_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            pat_mask[i] = (i < int'(len_reg));
        end
    end

    assign hit = accept && filled && (((history_next ^ pat_reg) & pat_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_reg     <= '0;
            len_reg     <= LEN_W'(1);
            overlap_reg <= 1'b0;
            history     <= '0;
            fill        <= '0;
        end else if (cfg_load) begin
            pat_reg     <= cfg_pat;
            len_reg     <= len_clamped;
            overlap_reg <= cfg_overlap;
            history     <= '0;
            fill        <= '0;
        end else if (accept) begin
            history <= history_next;
            // Non-overlapping mode discards the bits consumed by the match.
            fill    <= (hit && !overlap_reg) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= hit;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = ST_FILL;
        end else if (accept) begin
            if (hit && !overlap_reg) begin
                state_d = ST_FILL;
            end else if (filled) begin
                state_d = ST_HUNT;
            end else begin
                state_d = ST_FILL;
            end
        end
    end

    assign match = match_q;
    assign state = state_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // A clear coinciding with a hit still records that hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= hit ? CNT_W'(1) : '0;
        end else if (hit && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign match_count = count_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
